// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction field widths, word layout and memory mode type.
package instr_pkg;
  localparam int OPC_W = 4;
  localparam int SEL_W = 2;
  localparam int OPND_W = 16;
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [SEL_W-1:0] sel;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } instr_t;
  localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV = 4'b0001;
  typedef enum logic {LOAD, RUN} mode_t;
endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: unreset storage with one synchronous write port and one registered read port.
module instr_mem_array #(
  parameter int DATA_WIDTH = 38,
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_mem.sv
// instr_mem: loadable instruction store with LOAD/RUN control, range-checked registered fetch.
module instr_mem
  import instr_pkg::*;
#(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic                   load_done,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic                   fetch_valid,
  output logic                   fetch_fault,
  output logic                   cpu_hold,
  output logic [$clog2(DEPTH):0] load_count,
  output logic                   load_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  mode_t state, next_state;
  logic use_nop, in_range, accept, room, write;
  logic [DATA_WIDTH-1:0] rdata;
  assign cpu_hold = state == LOAD;
  assign in_range = {1'b0, fetch_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign accept = state == RUN && fetch_req && !load_start;
  assign room = load_count < CW'(DEPTH);
  assign write = state == LOAD && !load_start && load_valid && room;
  // a faulted fetch never reads the array, so the NOP is selected at the output
  assign instruction = use_nop ? NOP_WORD : rdata;
  always_comb begin
    next_state = load_start ? LOAD : (state == LOAD && load_done) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      load_count <= '0;
      load_overflow <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      use_nop <= 1'b1;
    end else begin
      state <= next_state;
      if (load_start) begin
        load_count <= '0;
        load_overflow <= 1'b0;
      end else if (state == LOAD && load_valid) begin
        if (room) load_count <= load_count + CW'(1);
        else load_overflow <= 1'b1;
      end
      fetch_valid <= accept;
      fetch_fault <= accept && !in_range;
      if (accept) use_nop <= !in_range;
    end
  end
  instr_mem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(write),
    .waddr(load_count[AW-1:0]),
    .wdata(load_data),
    .re(accept && in_range),
    .raddr(fetch_addr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed vector table plus hand sequences for overflow and reset-during-fetch.
module tb_instr_mem;
  localparam int DW = 38;
  localparam int AWID = 12;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] W0 = 38'h04_0000_000F;
  localparam logic [DW-1:0] W1 = 38'h04_1000_00FF;
  localparam logic [DW-1:0] WA = 38'h04_0000_00AA;
  localparam logic [DW-1:0] WX = 38'h3F_FFFF_FFFF;
  logic clk = 0, rst = 1;
  logic load_start = 0, load_valid = 0, load_done = 0, fetch_req = 0;
  logic [DW-1:0] load_data = '0;
  logic [AWID-1:0] fetch_addr = '0;
  logic [DW-1:0] instruction;
  logic fetch_valid, fetch_fault, cpu_hold, load_overflow;
  logic [6:0] load_count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  instr_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWID), .DEPTH(DEPTH), .NOP_WORD('0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .instruction(instruction), .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault), .cpu_hold(cpu_hold), .load_count(load_count),
    .load_overflow(load_overflow)
  );
  typedef struct {
    logic ls, lv, ld, fr;
    logic [AWID-1:0] fa;
    logic [DW-1:0] data;
    logic fv, ff, hold, ovf;
    logic [6:0] cnt;
    logic [DW-1:0] ins;
  } vec_t;
  vec_t v [25];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ls, lv, ld, fr, input logic [AWID-1:0] fa, input logic [DW-1:0] d);
    load_start = ls; load_valid = lv; load_done = ld; fetch_req = fr; fetch_addr = fa; load_data = d;
  endtask
  function automatic logic [DW-1:0] word(input int i);
    return 38'h20_0000_0000 | DW'(i);
  endfunction
  initial begin
    //      ls lv ld fr  fa     data  fv ff hd ov cnt ins
    v[0]  = '{0, 1, 0, 0, 12'd0,    W0, 0, 0, 1, 0, 1, '0};
    v[1]  = '{0, 1, 0, 0, 12'd0,    W1, 0, 0, 1, 0, 2, '0};
    v[2]  = '{0, 0, 1, 0, 12'd0,    '0, 0, 0, 0, 0, 2, '0};
    v[3]  = '{0, 0, 0, 1, 12'd0,    '0, 1, 0, 0, 0, 2, W0};
    v[4]  = '{0, 0, 0, 1, 12'd1,    '0, 1, 0, 0, 0, 2, W1};
    v[5]  = '{0, 0, 0, 1, 12'd64,   '0, 1, 1, 0, 0, 2, '0};
    v[6]  = '{0, 0, 0, 0, 12'd0,    '0, 0, 0, 0, 0, 2, '0};
    v[7]  = '{0, 0, 0, 1, 12'd4095, '0, 1, 1, 0, 0, 2, '0};
    v[8]  = '{0, 0, 0, 1, 12'd1,    '0, 1, 0, 0, 0, 2, W1};
    v[9]  = '{0, 0, 0, 0, 12'd0,    '0, 0, 0, 0, 0, 2, W1};
    v[10] = '{1, 0, 0, 1, 12'd0,    '0, 0, 0, 1, 0, 0, W1};
    v[11] = '{0, 0, 0, 1, 12'd0,    '0, 0, 0, 1, 0, 0, W1};
    v[12] = '{0, 0, 0, 1, 12'd0,    '0, 0, 0, 1, 0, 0, W1};
    v[13] = '{0, 0, 0, 1, 12'd0,    '0, 0, 0, 1, 0, 0, W1};
    v[14] = '{0, 1, 0, 0, 12'd0,    W0, 0, 0, 1, 0, 1, W1};
    v[15] = '{0, 1, 0, 0, 12'd0,    W1, 0, 0, 1, 0, 2, W1};
    v[16] = '{0, 1, 1, 0, 12'd0,    WA, 0, 0, 0, 0, 3, W1};
    v[17] = '{0, 0, 0, 1, 12'd2,    '0, 1, 0, 0, 0, 3, WA};
    v[18] = '{0, 0, 1, 1, 12'd0,    '0, 1, 0, 0, 0, 3, W0};
    v[19] = '{0, 1, 0, 0, 12'd0,    WX, 0, 0, 0, 0, 3, W0};
    v[20] = '{1, 1, 0, 0, 12'd0,    WX, 0, 0, 1, 0, 0, W0};
    v[21] = '{1, 1, 0, 0, 12'd0,    WX, 0, 0, 1, 0, 0, W0};
    v[22] = '{0, 0, 1, 0, 12'd0,    '0, 0, 0, 0, 0, 0, W0};
    v[23] = '{0, 0, 0, 1, 12'd0,    '0, 1, 0, 0, 0, 0, W0};
    v[24] = '{0, 0, 0, 1, 12'd2,    '0, 1, 0, 0, 0, 0, WA};
    step();
    step();
    chk("reset_hold", cpu_hold, 1);
    chk("reset_fv", fetch_valid, 0);
    chk("reset_ff", fetch_fault, 0);
    chk("reset_instr", instruction, 0);
    chk("reset_cnt", load_count, 0);
    chk("reset_ovf", load_overflow, 0);
    rst = 0;
    for (int i = 0; i < 25; i++) begin
      drive(v[i].ls, v[i].lv, v[i].ld, v[i].fr, v[i].fa, v[i].data);
      step();
      chk($sformatf("v%0d_fv", i), fetch_valid, v[i].fv);
      chk($sformatf("v%0d_ff", i), fetch_fault, v[i].ff);
      chk($sformatf("v%0d_hold", i), cpu_hold, v[i].hold);
      chk($sformatf("v%0d_ovf", i), load_overflow, v[i].ovf);
      chk($sformatf("v%0d_cnt", i), load_count, v[i].cnt);
      chk($sformatf("v%0d_instr", i), instruction, v[i].ins);
    end
    drive(1, 0, 0, 0, '0, '0);
    step();
    chk("ovf_start_cnt", load_count, 0);
    for (int i = 1; i <= 65; i++) begin
      drive(0, 1, 0, 0, '0, word(i));
      step();
      if (i == 64) begin
        chk("full_cnt", load_count, 64);
        chk("full_ovf", load_overflow, 0);
      end
    end
    chk("ovf_cnt", load_count, 64);
    chk("ovf_flag", load_overflow, 1);
    drive(0, 0, 1, 0, '0, '0);
    step();
    drive(0, 0, 0, 1, 12'd63, '0);
    step();
    chk("ovf_last_word", instruction, word(64));
    drive(0, 0, 0, 1, 12'd0, '0);
    step();
    chk("ovf_first_word", instruction, word(1));
    drive(1, 0, 0, 0, '0, '0);
    step();
    chk("restart_cnt", load_count, 0);
    chk("restart_ovf", load_overflow, 0);
    drive(0, 1, 0, 0, '0, W0);
    step();
    drive(0, 1, 0, 0, '0, W1);
    step();
    drive(0, 0, 1, 0, '0, '0);
    step();
    drive(0, 0, 0, 1, 12'd1, '0);
    step();
    chk("pre_rst_fv", fetch_valid, 1);
    rst = 1;
    #1;
    chk("rst_fv", fetch_valid, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_instr", instruction, 0);
    drive(0, 0, 0, 0, '0, '0);
    step();
    rst = 0;
    drive(0, 0, 1, 0, '0, '0);
    step();
    chk("post_rst_hold", cpu_hold, 0);
    chk("post_rst_cnt", load_count, 0);
    drive(0, 0, 0, 1, 12'd1, '0);
    step();
    chk("retained_fv", fetch_valid, 1);
    chk("retained_word", instruction, W1);
    drive(0, 0, 0, 0, '0, '0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
